// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
//   Scan-test sequencer for a single chain of scan flops. For each pattern it
//   shifts the stimulus in, pulses one capture cycle, and shifts the response
//   out. The response is compared against the pattern's expected value.
//   Unload of pattern n overlaps load of pattern n+1 whenever the next pattern
//   is offered during CAPTURE.
//
// Parameters
//   CHAIN_LEN  flops in the chain; width of pattern/expect/response (>=2)
//   CNT_W      width of pat_count / fail_count
//
// Ports
//   CK, RN                 clock, async active-low reset
//   pat_valid/pat_ready    pattern handshake; pat_data/pat_expect payload
//   SE, SI                 registered scan enable / scan data to the chain
//   SO                     scan out of the last chain flop
//   busy                   sequencer not idle
//   res_valid              one-cycle pulse when an unload completes
//   res_data, res_fail     unloaded response and mismatch flag (held)
//   pat_count              completed patterns (wraps)
//   fail_count             failing patterns (saturates)
//
// Optional build macro SCAN_MISR_EN adds:
//   sig_clr    (in)  clears the signature on the next edge
//   signature  (out) 16-bit MISR over every SO sample taken during unload

module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] pat_expect,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 busy,
    output logic                 res_valid,
    output logic [CHAIN_LEN-1:0] res_data,
    output logic                 res_fail,
    output logic [CNT_W-1:0]     pat_count,
    output logic [CNT_W-1:0]     fail_count
`ifdef SCAN_MISR_EN
    ,
    input  logic                 sig_clr,
    output logic [15:0]          signature
`endif
);

    localparam int             CW   = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0]  LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DRAIN} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   unl_pend;   // SHIFT also unloads the previous pattern
    logic [CHAIN_LEN-1:0]   ld_sh;      // load shifter, bit 0 = current SI bit
    logic [CHAIN_LEN-1:0]   exp_ld;     // expect of the pattern being loaded
    logic [CHAIN_LEN-1:0]   exp_unl;    // expect of the pattern being unloaded
    logic [CHAIN_LEN-1:0]   resp;

    logic                   accept;
    logic                   sampling;
    logic                   last;
    logic [CHAIN_LEN-1:0]   resp_nx;
    logic                   fail_nx;

    assign accept   = pat_valid & pat_ready;
    assign sampling = ((state == SHIFT) && unl_pend) || (state == DRAIN);
    assign last     = (cnt == LAST);
    assign busy     = (state != IDLE);

    // Response including the sample taken at this edge, so the final SO bit
    // lands in res_data on the completing edge.
    always_comb begin
        resp_nx      = resp;
        resp_nx[cnt] = SO;
    end

    assign fail_nx = (resp_nx != exp_unl);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state      <= IDLE;
            cnt        <= '0;
            unl_pend   <= 1'b0;
            ld_sh      <= '0;
            exp_ld     <= '0;
            exp_unl    <= '0;
            resp       <= '0;
            SE         <= 1'b0;
            SI         <= 1'b0;
            pat_ready  <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_fail   <= 1'b0;
            pat_count  <= '0;
            fail_count <= '0;
        end else begin
            res_valid <= 1'b0;

            if (sampling) resp <= resp_nx;

            if (sampling && last) begin
                res_valid <= 1'b1;
                res_data  <= resp_nx;
                res_fail  <= fail_nx;
                pat_count <= pat_count + CNT_W'(1);
                if (fail_nx && (fail_count != '1))
                    fail_count <= fail_count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        unl_pend  <= 1'b0;
                        cnt       <= '0;
                        SE        <= 1'b1;
                        SI        <= pat_data[0];
                        ld_sh     <= pat_data;
                        exp_ld    <= pat_expect;
                        pat_ready <= 1'b0;
                    end else begin
                        pat_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    ld_sh <= ld_sh >> 1;
                    if (last) begin
                        state     <= CAPTURE;
                        SE        <= 1'b0;
                        SI        <= 1'b0;
                        pat_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                        SI  <= ld_sh[1];
                    end
                end
                CAPTURE: begin
                    // Hand the just-loaded expect to the unload side before a
                    // newly accepted pattern overwrites exp_ld on this edge.
                    exp_unl   <= exp_ld;
                    cnt       <= '0;
                    SE        <= 1'b1;
                    pat_ready <= 1'b0;
                    if (accept) begin
                        state    <= SHIFT;
                        unl_pend <= 1'b1;
                        SI       <= pat_data[0];
                        ld_sh    <= pat_data;
                        exp_ld   <= pat_expect;
                    end else begin
                        state <= DRAIN;
                        SI    <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (last) begin
                        state     <= IDLE;
                        SE        <= 1'b0;
                        pat_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCAN_MISR_EN
    // CRC-16/1021 style signature over unload samples; clear wins over update.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN)
            signature <= 16'h0000;
        else if (sig_clr)
            signature <= 16'h0000;
        else if (sampling)
            signature <= {signature[14:0], 1'b0} ^ ({16{signature[15] ^ SO}} & 16'h1021);
    end
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (16-bit and 2-bit counters) each
// driving a model chain of 8 scan flops whose functional D is ~Q, so the
// unloaded response of any pattern is its bitwise complement.
module tb_scan_chain_ctrl;
    localparam int N = 8;

    typedef struct {
        logic [N-1:0] data;
        logic         fail;
    } res_t;

    logic         CK = 1'b0;
    logic         RN = 1'b1;
    logic         pat_valid = 1'b0;
    logic [N-1:0] pat_data = '0;
    logic [N-1:0] pat_expect = '0;

    logic         pat_ready, SE, SI, SO, busy, res_valid, res_fail;
    logic [N-1:0] res_data;
    logic [15:0]  pat_count, fail_count;

    logic         pat_ready2, SE2, SI2, SO2, busy2, res_valid2, res_fail2;
    logic [N-1:0] res_data2;
    logic [1:0]   pat_count2, fail_count2;

`ifdef SCAN_MISR_EN
    logic         sig_clr = 1'b0;
    logic [15:0]  signature, signature2;
`endif

    logic [N-1:0] ch1, ch2;

    res_t exp_q[$];
    int   n_chk = 0, n_pass = 0;
    int   mdl_pat = 0, mdl_fail = 0;
    int   cyc = 0, res_last = 0, res_prev = 0;

    always #5 CK = ~CK;

    scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(16)) dut (
        .CK(CK), .RN(RN), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_data(pat_data), .pat_expect(pat_expect), .SE(SE), .SI(SI), .SO(SO),
        .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_fail(res_fail),
        .pat_count(pat_count), .fail_count(fail_count)
`ifdef SCAN_MISR_EN
        , .sig_clr(sig_clr), .signature(signature)
`endif
    );

    scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(2)) dut2 (
        .CK(CK), .RN(RN), .pat_valid(pat_valid), .pat_ready(pat_ready2),
        .pat_data(pat_data), .pat_expect(pat_expect), .SE(SE2), .SI(SI2), .SO(SO2),
        .busy(busy2), .res_valid(res_valid2), .res_data(res_data2), .res_fail(res_fail2),
        .pat_count(pat_count2), .fail_count(fail_count2)
`ifdef SCAN_MISR_EN
        , .sig_clr(sig_clr), .signature(signature2)
`endif
    );

    // Scan chains: SE=1 shifts SI toward the last flop, SE=0 captures D=~Q.
    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            ch1 <= '0;
            ch2 <= '0;
        end else begin
            ch1 <= SE  ? {ch1[N-2:0], SI}  : ~ch1;
            ch2 <= SE2 ? {ch2[N-2:0], SI2} : ~ch2;
        end
    end
    assign SO  = ch1[N-1];
    assign SO2 = ch2[N-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] crc16(input logic [N-1:0] b);
        logic [15:0] s;
        s = 16'h0000;
        for (int k = 0; k < N; k++)
            s = {s[14:0], 1'b0} ^ (((s[15] ^ b[k]) != 1'b0) ? 16'h1021 : 16'h0000);
        return s;
    endfunction

    initial forever begin
        @(posedge CK);
        cyc++;
    end

    // Result monitor against the queue of expected results.
    initial begin : mon
        res_t r;
        forever begin
            @(negedge CK);
            if (!RN) begin
                exp_q.delete();
                mdl_pat  = 0;
                mdl_fail = 0;
            end else if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", res_valid, 0);
                end else begin
                    r = exp_q.pop_front();
                    mdl_pat++;
                    if (r.fail) mdl_fail++;
                    chk("res_data",    res_data,    r.data);
                    chk("res_fail",    res_fail,    r.fail);
                    chk("pat_count",   pat_count,   mdl_pat & 16'hffff);
                    chk("fail_count",  fail_count,  (mdl_fail > 65535) ? 65535 : mdl_fail);
                    chk("res_valid2",  res_valid2,  1);
                    chk("res_data2",   res_data2,   r.data);
                    chk("res_fail2",   res_fail2,   r.fail);
                    chk("pat_count2",  pat_count2,  mdl_pat % 4);
                    chk("fail_count2", fail_count2, (mdl_fail > 3) ? 3 : mdl_fail);
                end
                res_prev = res_last;
                res_last = cyc;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [N-1:0] d, input logic [N-1:0] e);
        int t;
        res_t r;
        t = 0;
        pat_valid  = 1'b1;
        pat_data   = d;
        pat_expect = e;
        while (!pat_ready && t < 100) begin
            @(negedge CK);
            t++;
        end
        if (!pat_ready) begin
            chk("accept_timeout", pat_ready, 1);
            pat_valid = 1'b0;
            return;
        end
        r.data = ~d;
        r.fail = ((~d) != e);
        exp_q.push_back(r);
        @(negedge CK);
        pat_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            @(negedge CK);
            t++;
        end
        if (t >= 200) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_se"},    SE,         0);
        chk({tag, "_si"},    SI,         0);
        chk({tag, "_rdy"},   pat_ready,  0);
        chk({tag, "_rv"},    res_valid,  0);
        chk({tag, "_rd"},    res_data,   0);
        chk({tag, "_rf"},    res_fail,   0);
        chk({tag, "_busy"},  busy,       0);
        chk({tag, "_pcnt"},  pat_count,  0);
        chk({tag, "_fcnt"},  fail_count, 0);
        chk({tag, "_fcnt2"}, fail_count2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] d, e;
        res_t r;
        #1 RN = 1'b0;
        repeat (3) @(negedge CK);
        chk_reset("rst");
        RN = 1'b1;

        // Idle with no patterns offered.
        for (int i = 0; i < 20; i++) begin
            @(negedge CK);
            chk("idle_se",   SE,         0);
            chk("idle_busy", busy,       0);
            chk("idle_rdy",  pat_ready,  1);
            chk("idle_rdy2", pat_ready2, 1);
            chk("idle_busy2", busy2,     0);
        end

        // Single pattern, cycle-exact latency.
        pat_valid  = 1'b1;
        pat_data   = 8'hA5;
        pat_expect = 8'h5A;
        r.data = 8'h5A;
        r.fail = 1'b0;
        exp_q.push_back(r);
        @(negedge CK);
        pat_valid = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) @(negedge CK);
            if (k <= 8)  chk("lat_se_shift", SE, 1);
            if (k == 9)  chk("lat_se_capture", SE, 0);
            if (k == 9)  chk("lat_rdy_capture", pat_ready, 1);
            if (k == 10) chk("lat_se_drain", SE, 1);
            if (k == 17) chk("lat_rv_early", res_valid, 0);
            if (k == 18) begin
                chk("lat_rv", res_valid, 1);
                chk("lat_rdy_idle", pat_ready, 1);
                chk("lat_busy_idle", busy, 0);
            end
        end
        wait_idle();

        // Back-to-back: second pattern accepted in CAPTURE.
        send(8'hFF, 8'h00);
        send(8'h0F, 8'h00);
        wait_idle();
        chk("b2b_gap", res_last - res_prev, N + 1);
        chk("b2b_fcnt", fail_count, 1);

        // Reset in cycle 5 of SHIFT aborts the pattern.
        send(8'h96, 8'h69);
        repeat (4) @(negedge CK);
        RN = 1'b0;
        @(negedge CK);
        chk_reset("rst_mid");
        @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        send(8'h3C, 8'hC3);
        wait_idle();
        chk("post_rst_pcnt", pat_count, 1);
        chk("post_rst_data", res_data, 8'hC3);
        chk("post_rst_fail", res_fail, 0);

        // Saturation of the 2-bit fail counter.
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send(d, d);
        end
        wait_idle();
        chk("sat_fcnt2", fail_count2, 3);
        chk("sat_fcnt",  fail_count,  4);
        chk("sat_pcnt2", pat_count2,  1);

`ifdef SCAN_MISR_EN
        sig_clr = 1'b1;
        @(negedge CK);
        sig_clr = 1'b0;
        chk("sig_clr", signature, 0);
        send(8'hA5, 8'h5A);
        wait_idle();
        chk("sig",  signature,  crc16(8'h5A));
        chk("sig2", signature2, crc16(8'h5A));
`endif

        // Random traffic with random gaps (0 gap exercises overlap).
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge CK);
            d = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? ~d : 8'($urandom);
            send(d, e);
        end
        wait_idle();
        chk("rand_pcnt", pat_count, mdl_pat & 16'hffff);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
